// File: rtl/mux_reg_pkg.sv
// Shared constants for the registered N-way stream mux: mode encodings,
// reset values and the select-width helper.
package mux_reg_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;

    localparam logic        RST_VALID = 1'b0;
    localparam logic        RST_ERR   = 1'b0;
    localparam int unsigned RST_DATA  = 0;
    localparam int unsigned RST_SEL   = 0;
    localparam int unsigned RST_PTR   = 0;

    // Width of a channel index; at least one bit even for two channels.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// Round-robin scan pointer with a wrap-around search for the next enabled
// channel; the mask is all ones unless MUXREG_CH_MASK_EN is used at the top.
module mux_scan_ptr
    import mux_reg_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  en_mask,
    input  logic             advance,
    output logic [SEL_W-1:0] cur_idx,
    output logic             any_en
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] nxt_start;
    logic [SEL_W-1:0] nxt_idx;

    // First enabled channel at or after start, wrapping past N_CH-1.
    function automatic logic [SEL_W-1:0] find_en(input logic [N_CH-1:0]  m,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   idx;
        logic             found;
        logic [SEL_W-1:0] res;
        found = 1'b0;
        res   = start;
        for (int k = 0; k < N_CH; k++) begin
            idx = {1'b0, start} + (SEL_W+1)'(k);
            if (idx >= (SEL_W+1)'(N_CH)) begin
                idx = idx - (SEL_W+1)'(N_CH);
            end
            if (!found && m[idx[SEL_W-1:0]]) begin
                found = 1'b1;
                res   = idx[SEL_W-1:0];
            end
        end
        return res;
    endfunction

    always_comb begin
        any_en    = |en_mask;
        cur_idx   = find_en(en_mask, ptr_q);
        nxt_start = (cur_idx == SEL_W'(N_CH-1)) ? '0 : cur_idx + SEL_W'(1);
        nxt_idx   = find_en(en_mask, nxt_start);
        ptr_d     = advance ? nxt_idx : ptr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= SEL_W'(RST_PTR);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_n_reg_stream.sv
// N_CH-way registered mux with valid/ready output, direct or auto-scan select.
// Optional channel mask enabled by defining MUXREG_CH_MASK_EN.
module mux_n_reg_stream
    import mux_reg_pkg::*;
#(
    parameter  int XLEN  = 5,
    parameter  int N_CH  = 8,
    localparam int SEL_W = sel_width(N_CH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_CH*XLEN-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     select,
    input  logic                 mode,
`ifdef MUXREG_CH_MASK_EN
    input  logic [N_CH-1:0]      ch_mask,
`endif
    output logic [XLEN-1:0]      out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_err
);

    logic [N_CH-1:0]  mask;
    logic [XLEN-1:0]  chan [N_CH];
    logic [SEL_W-1:0] cur_idx;
    logic             any_en;
    logic             auto_mode;
    logic             capture;
    logic             sel_in_range;
    logic [SEL_W-1:0] cap_sel;
    logic [SEL_W-1:0] safe_idx;
    logic             cap_err;
    logic [XLEN-1:0]  cap_data;

    logic [XLEN-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             out_err_q,   out_err_d;

`ifdef MUXREG_CH_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        assign chan[g] = in_data[g*XLEN +: XLEN];
    end

    mux_scan_ptr #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_scan_ptr (
        .clock   (clock),
        .reset   (reset),
        .en_mask (mask),
        .advance (capture && auto_mode),
        .cur_idx (cur_idx),
        .any_en  (any_en)
    );

    // An empty mask blocks auto-scan captures; direct mode still captures as an error.
    always_comb begin
        auto_mode = (mode == MODE_AUTO);
        in_ready  = (!out_valid_q || out_ready) && !(auto_mode && !any_en);
        capture   = in_valid && in_ready;
    end

    always_comb begin
        sel_in_range = ({1'b0, select} < (SEL_W+1)'(N_CH));
        cap_err      = 1'b0;
        if (auto_mode) begin
            cap_sel = cur_idx;
        end else begin
            cap_sel = select;
            if (!sel_in_range) begin
                cap_err = 1'b1;
            end else if (!mask[select]) begin
                cap_err = 1'b1;
            end
        end
        safe_idx = cap_err ? '0 : cap_sel;
        cap_data = cap_err ? '0 : chan[safe_idx];
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_data_d  = cap_data;
            out_sel_d   = cap_sel;
            out_err_d   = cap_err;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_data_q  <= XLEN'(RST_DATA);
            out_sel_q   <= SEL_W'(RST_SEL);
            out_valid_q <= RST_VALID;
            out_err_q   <= RST_ERR;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule
